// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window controller: pixel width,
// 3x3 window element indices and the frame sequencer states.
package sobel_pkg;

  localparam int unsigned PW = 16;

  // Element pxRC sits at slot (R-1)*3 + (C-1) of the flattened window.
  localparam int unsigned PX11_IDX = 0;
  localparam int unsigned PX12_IDX = 1;
  localparam int unsigned PX13_IDX = 2;
  localparam int unsigned PX21_IDX = 3;
  localparam int unsigned PX22_IDX = 4;
  localparam int unsigned PX23_IDX = 5;
  localparam int unsigned PX31_IDX = 6;
  localparam int unsigned PX32_IDX = 7;
  localparam int unsigned PX33_IDX = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream input and window/status output bundle of the Sobel window
// controller; master is the source/core side, slave is the controller.
interface sobel_window_ctrl_if #(
  parameter int unsigned PW = 16,
  parameter int unsigned CW = 10,
  parameter int unsigned RW = 9
) ();

  logic            frame_start;
  logic [PW-1:0]   pix_in;
  logic            pix_valid;
  logic            pix_ready;
  logic [9*PW-1:0] win_bus;
  logic            win_start;
  logic [RW-1:0]   win_row;
  logic [CW-1:0]   win_col;
  logic            busy;
  logic            frame_done;

  modport master (
    output frame_start, pix_in, pix_valid,
    input  pix_ready, win_bus, win_start, win_row, win_col, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_in, pix_valid,
    output pix_ready, win_bus, win_start, win_row, win_col, busy, frame_done
  );

endinterface

// File: rtl/sobel_line_buf.sv
// Two cascaded DEPTH-deep delay lines sharing one enable; tap1 is the pixel
// one row back, tap2 two rows back. Contents are intentionally not reset.
module sobel_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned PW    = 16
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] tap1_o,
  output logic [PW-1:0] tap2_o
);

  logic [PW-1:0] l1_q [DEPTH];
  logic [PW-1:0] l2_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      l1_q[0] <= din_i;
      l2_q[0] <= l1_q[DEPTH-1];
      for (int unsigned i = 1; i < DEPTH; i++) begin
        l1_q[i] <= l1_q[i-1];
        l2_q[i] <= l2_q[i-1];
      end
    end
  end

  assign tap1_o = l1_q[DEPTH-1];
  assign tap2_o = l2_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-scan front end for the Sobel core: buffers two rows, assembles the
// 3x3 neighbourhood and pulses win_start once per interior window.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PW    = sobel_pkg::PW,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 reset,
  sobel_window_ctrl_if.slave   bus
);

  state_t          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            pix_ready_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            win_start_q;
  logic [9*PW-1:0] win_bus_q;
  logic [9*PW-1:0] win_d;
  logic [RW-1:0]   win_row_q;
  logic [CW-1:0]   win_col_q;

  logic [PW-1:0]   tap1, tap2;
  logic [PW-1:0]   top_q [2];
  logic [PW-1:0]   mid_q [2];
  logic [PW-1:0]   bot_q [2];

  logic accept, col_wrap, last_pix, interior;

  // A pixel that coincides with frame_start is dropped, not accepted.
  assign accept   = (state_q == STREAM) && bus.pix_valid && !bus.frame_start;
  assign col_wrap = (col_q == CW'(IMG_W-1));
  assign last_pix = col_wrap && (row_q == RW'(IMG_H-1));
  assign interior = (row_q >= RW'(2)) && (col_q >= CW'(2));

  sobel_line_buf #(.DEPTH(IMG_W), .PW(PW)) u_lb (
    .clk    (clk),
    .en_i   (accept),
    .din_i  (bus.pix_in),
    .tap1_o (tap1),
    .tap2_o (tap2)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      top_q[0] <= top_q[1];
      top_q[1] <= tap2;
      mid_q[0] <= mid_q[1];
      mid_q[1] <= tap1;
      bot_q[0] <= bot_q[1];
      bot_q[1] <= bus.pix_in;
    end
  end

  always_comb begin
    win_d = '0;
    win_d[PX11_IDX*PW +: PW] = top_q[0];
    win_d[PX12_IDX*PW +: PW] = top_q[1];
    win_d[PX13_IDX*PW +: PW] = tap2;
    win_d[PX21_IDX*PW +: PW] = mid_q[0];
    win_d[PX22_IDX*PW +: PW] = mid_q[1];
    win_d[PX23_IDX*PW +: PW] = tap1;
    win_d[PX31_IDX*PW +: PW] = bot_q[0];
    win_d[PX32_IDX*PW +: PW] = bot_q[1];
    win_d[PX33_IDX*PW +: PW] = bus.pix_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      win_start_q  <= 1'b0;
      win_bus_q    <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            state_q     <= STREAM;
            col_q       <= '0;
            row_q       <= '0;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.frame_start) begin
            col_q <= '0;
            row_q <= '0;
          end else if (bus.pix_valid) begin
            if (interior) begin
              win_start_q <= 1'b1;
              win_bus_q   <= win_d;
              win_row_q   <= row_q - RW'(1);
              win_col_q   <= col_q - CW'(1);
            end
            if (col_wrap) begin
              col_q <= '0;
              row_q <= last_pix ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (last_pix) begin
              state_q      <= DONE;
              pix_ready_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_start  = win_start_q;
  assign bus.win_bus    = win_bus_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 5x4 image: the driver keeps a
// frame image and pushes expected windows; a monitor pops on win_start.
module tb_sobel_window_ctrl;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int PWT = 16;
  localparam int CWT = 3;
  localparam int RWT = 2;
  localparam int BW  = 9 * PWT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_window_ctrl_if #(.PW(PWT), .CW(CWT), .RW(RWT)) bus ();

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PW(PWT), .CW(CWT), .RW(RWT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [BW-1:0] win;
    int            row;
    int            col;
  } win_t;

  win_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  bit            exp_pulse = 0;
  bit            exp_done  = 0;
  bit            m_stream  = 0;
  int            m_idx     = 0;
  logic [PWT-1:0] img [H][W];
  int            pulse_cnt = 0;
  int            done_cnt  = 0;
  logic [BW-1:0] first_win, last_win;
  int            first_row, first_col;
  bit            first_seen = 0;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PWT-1:0] elem(input logic [BW-1:0] w, input int idx);
    logic [BW-1:0] t;
    t = w;
    return t[idx*PWT +: PWT];
  endfunction

  // Monitor: cycle-exact pulse/done/busy checks plus window scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("win_start_timing", BW'(bus.win_start), BW'(exp_pulse));
      chk("frame_done_timing", BW'(bus.frame_done), BW'(exp_done));
      chk("busy", BW'(bus.busy), BW'(m_stream || exp_done));
      if (bus.frame_done) done_cnt++;
      if (bus.win_start) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL window_unexpected: got win_bus %0h with empty queue", bus.win_bus);
        end else begin
          win_t w;
          w = exp_q.pop_front();
          chk("win_bus", bus.win_bus, w.win);
          chk("win_row", BW'(bus.win_row), BW'(w.row));
          chk("win_col", BW'(bus.win_col), BW'(w.col));
        end
        if (!first_seen) begin
          first_seen = 1;
          first_win  = bus.win_bus;
          first_row  = int'(bus.win_row);
          first_col  = int'(bus.win_col);
        end
        last_win = bus.win_bus;
      end
    end
  end

  function automatic win_t build(input int r, input int c);
    win_t w;
    w.win = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w.win[(rr*3 + cc)*PWT +: PWT] = img[r-2+rr][c-2+cc];
    w.row = r - 1;
    w.col = c - 1;
    return w;
  endfunction

  // One clock of stimulus; the model advances with the same edge.
  task automatic step(input bit fs, input bit v, input logic [PWT-1:0] pix);
    bit acc, in_done;
    int r, c;
    @(negedge clk);
    bus.frame_start = fs;
    bus.pix_valid   = v;
    bus.pix_in      = pix;
    chk("pix_ready", BW'(bus.pix_ready), BW'(m_stream));
    acc     = m_stream && v && !fs;
    in_done = exp_done;
    @(posedge clk);
    exp_pulse = 0;
    exp_done  = 0;
    if (fs && m_stream) m_idx = 0;
    else if (fs && !in_done) begin
      m_stream = 1;
      m_idx    = 0;
    end
    if (acc) begin
      r = m_idx / W;
      c = m_idx % W;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(build(r, c));
        exp_pulse = 1;
      end
      m_idx++;
      if (m_idx == W*H) begin
        m_stream = 0;
        exp_done = 1;
      end
    end
  endtask

  function automatic logic [PWT-1:0] pix_of(input int mode, input int idx);
    if (mode == 0) return PWT'(10*(idx / W) + (idx % W));
    if (mode == 1) return PWT'(200);
    return PWT'($urandom());
  endfunction

  // vmode: 0 continuous, 1 toggling 1,0,1,0, 2 random gaps.
  task automatic run_frame(input int mode, input int vmode, input bit fs_in_done);
    int n;
    bit v;
    step(1, 0, '0);
    n = 0;
    while (m_stream && n < 400) begin
      if (vmode == 0) v = 1;
      else if (vmode == 1) v = (n % 2 == 0);
      else v = ($urandom_range(0, 3) != 0);
      step(0, v, pix_of(mode, m_idx));
      n++;
    end
    if (m_stream) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d accepts expected %0d", m_idx, W*H);
      m_stream = 0;
    end
    step(fs_in_done, 0, '0);
  endtask

  task automatic partial(input int n_acc);
    step(1, 0, '0);
    for (int i = 0; i < n_acc; i++) step(0, 1, pix_of(2, m_idx));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_win_bus"},    bus.win_bus, '0);
    chk({tag, "_win_start"},  BW'(bus.win_start), '0);
    chk({tag, "_win_row"},    BW'(bus.win_row), '0);
    chk({tag, "_win_col"},    BW'(bus.win_col), '0);
    chk({tag, "_busy"},       BW'(bus.busy), '0);
    chk({tag, "_frame_done"}, BW'(bus.frame_done), '0);
    chk({tag, "_pix_ready"},  BW'(bus.pix_ready), '0);
  endtask

  task automatic clear_counts();
    pulse_cnt  = 0;
    done_cnt   = 0;
    first_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.frame_start = 0;
    bus.pix_valid   = 0;
    bus.pix_in      = '0;
    reset = 0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset  = 1;
    mon_en = 1;

    // Directed ramp 10*r+c, continuous valid.
    clear_counts();
    run_frame(0, 0, 0);
    chk("ramp_pulses", BW'(pulse_cnt), BW'(6));
    chk("ramp_done", BW'(done_cnt), BW'(1));
    chk("ramp_first_px11", BW'(elem(first_win, sobel_pkg::PX11_IDX)), BW'(0));
    chk("ramp_first_px22", BW'(elem(first_win, sobel_pkg::PX22_IDX)), BW'(11));
    chk("ramp_first_px33", BW'(elem(first_win, sobel_pkg::PX33_IDX)), BW'(22));
    chk("ramp_first_row", BW'(first_row), BW'(1));
    chk("ramp_first_col", BW'(first_col), BW'(1));
    chk("ramp_last_px33", BW'(elem(last_win, sobel_pkg::PX33_IDX)), BW'(34));

    // Constant image; frame_start during DONE must be ignored.
    clear_counts();
    run_frame(1, 0, 1);
    step(0, 0, '0);
    chk("const_pulses", BW'(pulse_cnt), BW'(6));
    chk("const_last_win", last_win, {9{16'd200}});
    chk("const_done", BW'(done_cnt), BW'(1));

    // Toggling valid.
    clear_counts();
    run_frame(0, 1, 0);
    chk("toggle_pulses", BW'(pulse_cnt), BW'(6));
    chk("toggle_last_px33", BW'(elem(last_win, sobel_pkg::PX33_IDX)), BW'(34));

    // Abort after 7 accepts, then a full frame.
    clear_counts();
    partial(7);
    run_frame(0, 0, 0);
    chk("abort_pulses", BW'(pulse_cnt), BW'(6));
    chk("abort_done", BW'(done_cnt), BW'(1));

    // Reset mid-stream after 12 accepts.
    clear_counts();
    partial(12);
    @(negedge clk);
    #2 reset = 0;
    #1 check_reset_outputs("midrst");
    m_stream  = 0;
    m_idx     = 0;
    exp_pulse = 0;
    exp_done  = 0;
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1;
    clear_counts();
    run_frame(2, 2, 0);
    chk("midrst_pulses", BW'(pulse_cnt), BW'(6));
    chk("midrst_done", BW'(done_cnt), BW'(1));

    // Back-to-back random frames with random gaps.
    clear_counts();
    run_frame(2, 2, 0);
    run_frame(2, 0, 0);
    chk("b2b_pulses", BW'(pulse_cnt), BW'(12));
    chk("b2b_done", BW'(done_cnt), BW'(2));

    repeat (3) step(0, 0, '0);
    chk("queue_drained", BW'(exp_q.size()), BW'(0));
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
